// File: rtl/can_bus_if.sv
// can_bus_if: host-facing pins of the 8-bit multiplexed Intel-mode CAN bus.
//   can_ad_i   host -> responder address/data
//   can_ad_o   responder -> host read data
//   can_ad_oe  responder drives AD when 1
//   can_ale    address latch enable (active high)
//   can_cs_n, can_rd_n, can_wr_n  chip select / read / write strobes (active low)
//   can_rst_n  bus-side controller reset (active low)
//   can_int_n  interrupt toward host (active low)
interface can_bus_if;
  logic [7:0] can_ad_i;
  logic [7:0] can_ad_o;
  logic       can_ad_oe;
  logic       can_ale;
  logic       can_cs_n;
  logic       can_rd_n;
  logic       can_wr_n;
  logic       can_rst_n;
  logic       can_int_n;

  modport master (
    output can_ad_i, can_ale, can_cs_n, can_rd_n, can_wr_n, can_rst_n,
    input  can_ad_o, can_ad_oe, can_int_n
  );

  modport slave (
    input  can_ad_i, can_ale, can_cs_n, can_rd_n, can_wr_n, can_rst_n,
    output can_ad_o, can_ad_oe, can_int_n
  );
endinterface

// File: rtl/can_bus_responder.sv
// can_bus_responder: controller-side end of the multiplexed CAN controller bus.
// Emulates a 32 x 8 register file (0 mode, 3 IR read-clear, 4 IER, rest R/W),
// interrupt register and active-low INT generation.
//   clk, rst    system clock, synchronous active-high reset
//   bus         can_bus_if.slave pin bundle
//   irq_set_i   one-cycle pulses setting IR bits
//   wr_evt_o    one-cycle pulse per committed bus write
//   wr_addr_o   address of last committed write
//   wr_data_o   data of last committed write
module can_bus_responder #(
  parameter logic [7:0] RST_MODE_VAL = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  can_bus_if.slave   bus,
  input  logic [7:0] irq_set_i,
  output logic       wr_evt_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_RD, S_WR} state_e;

  // Two-flop synchronizers; control order {ale, cs_n, rd_n, wr_n, rst_n}.
  logic [7:0] ad_m_q, ad_s_q;
  logic [4:0] ctl_m_q, ctl_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ad_m_q  <= '0;
      ad_s_q  <= '0;
      ctl_m_q <= 5'b01111;
      ctl_s_q <= 5'b01111;
    end else begin
      ad_m_q  <= bus.can_ad_i;
      ad_s_q  <= ad_m_q;
      ctl_m_q <= {bus.can_ale, bus.can_cs_n, bus.can_rd_n, bus.can_wr_n, bus.can_rst_n};
      ctl_s_q <= ctl_m_q;
    end
  end

  logic ale_s, cs_s, rd_s, wr_s, rst_n_s;
  assign {ale_s, cs_s, rd_s, wr_s, rst_n_s} = ctl_s_q;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] regs_q [32];
  logic [7:0] regs_d [32];
  logic [7:0] ir_q, ir_d;
  logic [7:0] ad_o_q, ad_o_d;
  logic       oe_q, oe_d;
  logic       int_n_q, int_n_d;
  logic       wr_evt_q, wr_evt_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       ir_clr;
  logic       commit;
  logic [7:0] rd_data;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    regs_d    = regs_q;
    wr_evt_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ir_clr    = 1'b0;
    commit    = 1'b0;

    if (ale_s) addr_d = ad_s_q;

    case (state_q)
      S_IDLE: if (ale_s) state_d = S_ADDR;
      S_ADDR: if (!ale_s) state_d = S_WAIT;
      S_WAIT: begin
        if (!cs_s && !rd_s)      state_d = S_RD;
        else if (!cs_s && !wr_s) state_d = S_WR;
        else if (ale_s)          state_d = S_ADDR;
      end
      S_RD: begin
        if (rd_s || cs_s) begin
          state_d = S_IDLE;
          ir_clr  = (addr_q == 8'd3);
        end
      end
      S_WR: begin
        data_d = ad_s_q;
        if (wr_s) begin
          state_d = S_IDLE;
          commit  = !cs_s;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      wr_evt_d  = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = data_q;
      if (addr_q < 8'd32 && addr_q != 8'd3) regs_d[addr_q[4:0]] = data_q;
    end

    // Set wins over read-clear in the same cycle.
    ir_d = (ir_q & ~{8{ir_clr}}) | irq_set_i;

    // Bus-side reset overrides everything computed above.
    if (!rst_n_s) begin
      state_d  = S_IDLE;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_evt_d = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ir_d     = '0;
      for (int unsigned i = 0; i < 32; i++) regs_d[i] = (i == 0) ? RST_MODE_VAL : '0;
    end

    if (addr_q >= 8'd32)     rd_data = '0;
    else if (addr_q == 8'd3) rd_data = ir_q;
    else                     rd_data = regs_q[addr_q[4:0]];

    // Drive registered so the pin reflects the state being entered.
    oe_d    = (state_d == S_RD);
    ad_o_d  = oe_d ? rd_data : '0;
    int_n_d = ~|(ir_q & regs_q[4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      ir_q      <= '0;
      ad_o_q    <= '0;
      oe_q      <= 1'b0;
      int_n_q   <= 1'b1;
      wr_evt_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= (i == 0) ? RST_MODE_VAL : '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ir_q      <= ir_d;
      ad_o_q    <= ad_o_d;
      oe_q      <= oe_d;
      int_n_q   <= int_n_d;
      wr_evt_q  <= wr_evt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      regs_q    <= regs_d;
    end
  end

  assign bus.can_ad_o  = ad_o_q;
  assign bus.can_ad_oe = oe_q;
  assign bus.can_int_n = int_n_q;
  assign wr_evt_o      = wr_evt_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;

endmodule

// File: tb/tb_can_bus_responder.sv
// tb_can_bus_responder: host-side pin sequences against a register-map model.
module tb_can_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_set;
  logic       wr_evt;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  can_bus_if bus_if();

  can_bus_responder #(.RST_MODE_VAL(8'h01)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .irq_set_i (irq_set),
    .wr_evt_o  (wr_evt),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int evt_cnt = 0;

  always @(negedge clk) if (wr_evt) evt_cnt++;

  // Behavioural model of the register map.
  logic [7:0] mem [32];
  logic [7:0] ir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h01;
    ir = 8'h00;
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    if (a >= 8'd32) return 8'h00;
    if (a == 8'd3)  return ir;
    return mem[a[4:0]];
  endfunction

  function automatic logic exp_int_n();
    return ~|(ir & mem[4]);
  endfunction

  task automatic bus_addr(input logic [7:0] a);
    bus_if.can_ad_i = a;
    bus_if.can_ale  = 1'b1;
    cyc(4);
    bus_if.can_ale  = 1'b0;
    cyc(4);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int e0;
    e0 = evt_cnt;
    bus_addr(a);
    bus_if.can_ad_i = d;
    bus_if.can_cs_n = 1'b0;
    bus_if.can_wr_n = 1'b0;
    cyc(4);
    bus_if.can_wr_n = 1'b1;
    cyc(4);
    bus_if.can_cs_n = 1'b1;
    cyc(4);
    chk("wr_evt_count", evt_cnt - e0, 1);
    chk("wr_addr", wr_addr, a);
    chk("wr_data", wr_data, d);
    if (a < 8'd32 && a != 8'd3) mem[a[4:0]] = d;
    chk("int_n_after_wr", bus_if.can_int_n, exp_int_n());
  endtask

  // irq_v is pulsed on irq_set_i in the cycle the read access ends.
  task automatic do_read(input logic [7:0] a, input logic [7:0] irq_v);
    logic [7:0] e;
    e = exp_rd(a);
    bus_addr(a);
    bus_if.can_cs_n = 1'b0;
    bus_if.can_rd_n = 1'b0;
    cyc(2);
    chk("rd_oe_early", bus_if.can_ad_oe, 0);
    cyc(1);
    chk("rd_oe_on", bus_if.can_ad_oe, 1);
    chk("rd_data", bus_if.can_ad_o, e);
    cyc(2);
    bus_if.can_rd_n = 1'b1;
    cyc(2);
    chk("rd_oe_hold", bus_if.can_ad_oe, 1);
    irq_set = irq_v;
    cyc(1);
    irq_set = 8'h00;
    chk("rd_oe_off", bus_if.can_ad_oe, 0);
    bus_if.can_cs_n = 1'b1;
    cyc(3);
    ir = (a == 8'd3) ? irq_v : (ir | irq_v);
    chk("int_n_after_rd", bus_if.can_int_n, exp_int_n());
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    logic old_n;
    old_n = exp_int_n();
    irq_set = v;
    cyc(1);
    irq_set = 8'h00;
    chk("irq_int_n_lat1", bus_if.can_int_n, old_n);
    ir = ir | v;
    cyc(1);
    chk("irq_int_n_lat2", bus_if.can_int_n, exp_int_n());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, d;
    int e0;
    logic [7:0] wa0;
    rst = 1'b1;
    irq_set = 8'h00;
    bus_if.can_ad_i  = 8'h00;
    bus_if.can_ale   = 1'b0;
    bus_if.can_cs_n  = 1'b1;
    bus_if.can_rd_n  = 1'b1;
    bus_if.can_wr_n  = 1'b1;
    bus_if.can_rst_n = 1'b1;
    model_reset();
    cyc(5);
    rst = 1'b0;
    chk("rst_ad_oe", bus_if.can_ad_oe, 0);
    chk("rst_ad_o", bus_if.can_ad_o, 0);
    chk("rst_int_n", bus_if.can_int_n, 1);
    chk("rst_wr_evt", wr_evt, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    cyc(3);

    do_read(8'h00, 8'h00);
    do_read(8'h05, 8'h00);

    do_write(8'h07, 8'hA5);
    do_read(8'h07, 8'h00);

    do_write(8'h04, 8'h01);
    pulse_irq(8'h01);
    do_read(8'h03, 8'h00);

    // Set arriving together with the read-clear survives.
    pulse_irq(8'h01);
    do_read(8'h03, 8'h02);
    do_read(8'h03, 8'h00);

    pulse_irq(8'h04);
    do_write(8'h03, 8'hFF);
    do_read(8'h03, 8'h00);
    do_write(8'h40, 8'h77);
    do_read(8'h40, 8'h00);

    // Abort: cs_n released before wr_n.
    e0 = evt_cnt;
    wa0 = wr_addr;
    bus_addr(8'h07);
    bus_if.can_ad_i = 8'h33;
    bus_if.can_cs_n = 1'b0;
    bus_if.can_wr_n = 1'b0;
    cyc(4);
    bus_if.can_cs_n = 1'b1;
    cyc(4);
    bus_if.can_wr_n = 1'b1;
    cyc(5);
    chk("abort_no_evt", evt_cnt - e0, 0);
    chk("abort_wr_addr", wr_addr, wa0);
    do_read(8'h07, 8'h00);

    // Bus-side reset restores the register map.
    do_write(8'h07, 8'h55);
    pulse_irq(8'h10);
    bus_if.can_rst_n = 1'b0;
    cyc(4);
    bus_if.can_rst_n = 1'b1;
    cyc(4);
    model_reset();
    do_read(8'h07, 8'h00);
    do_read(8'h00, 8'h00);
    do_read(8'h03, 8'h00);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 8'h20 + 8'($urandom_range(0, 31));
      else                           a = 8'($urandom_range(0, 31));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       do_write(a, d);
        1:       do_read(a, ($urandom_range(0, 3) == 0) ? d : 8'h00);
        default: pulse_irq(d);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_bus_responder.md
# can_bus_responder

Bus-slave end of the 8-bit multiplexed Intel-mode CAN controller bus (AD/ALE/CS_n/RD_n/WR_n/INT_n). It emulates the controller side with a 32 x 8 register file, interrupt register and INT_n generation. It sits on the FPGA pins facing an external host, or inside a testbench facing the host-side bus initiator. It also exposes a local port for injecting interrupt sources and observing writes.

## Interface
- RST_MODE_VAL, 8'h01, reset value of register 0 (mode).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- can_ad_i  in  8  AD bus as driven by host.
- can_ad_o  out  8  read data driven toward host.
- can_ad_oe  out  1  1 = responder drives AD.
- can_ale  in  1  address latch enable, active high.
- can_cs_n, can_rd_n, can_wr_n  in  1 each  chip select / read / write strobes, active low.
- can_rst_n  in  1  bus-side controller reset, active low.
- can_int_n  out  1  interrupt, active low.
- irq_set_i  in  8  one-cycle pulses that set IR bits.
- wr_evt_o  out  1  one-cycle pulse per committed bus write.
- wr_addr_o  out  8  address of last committed write.
- wr_data_o  out  8  data of last committed write.

## Operation
- All bus inputs (ad, ale, cs_n, rd_n, wr_n, rst_n) pass through 2-flop synchronizers (`*_s`). All decisions use synchronized values.
- Address latch: addr_q <= ad_s in every cycle where ale_s=1. addr_q holds while ale_s=0.
- Register map: 0 mode (reset RST_MODE_VAL); 3 IR (read-only from bus, read-clear); 4 IER; others generic R/W, reset 0. addr_q >= 32 reads 0x00; writes there are ignored but still pulse wr_evt_o.
- FSM states:
  - IDLE -> ADDR when ale_s=1.
  - ADDR -> WAIT when ale_s=0.
  - WAIT:
    - -> RD when cs_s=0 & rd_s=0. Read has priority if wr_s is also 0; no write commits in that case.
    - -> WR when cs_s=0 & wr_s=0 & rd_s=1.
    - -> ADDR when ale_s=1.
  - RD: can_ad_oe=1, can_ad_o=reg[addr_q]. Exit to IDLE when rd_s=1 or cs_s=1. On exit, if addr_q=3, IR is cleared.
  - WR: data_q <= ad_s in every cycle. Exit to IDLE when wr_s=1:
    - if cs_s=0 in that cycle: commit data_q to reg[addr_q] (ignored for 3 and >= 32), pulse wr_evt_o, update wr_addr_o/wr_data_o.
    - if cs_s=1 (cs deasserted before wr): abort, no commit.
- IR update: IR <= (IR & ~clr) | irq_set_i. Set wins over read-clear in the same cycle.
- can_int_n <= ~|(IR & IER), registered.
- can_rst_n_s=0: register file returns to its reset values, IR=0, FSM to IDLE, can_ad_oe=0. Bus accesses are ignored while it is held.

## Timing
- Reset values (rst=1): can_ad_o=0, can_ad_oe=0, can_int_n=1, wr_evt_o=0, wr_addr_o=0, wr_data_o=0, addr_q=0, FSM=IDLE, registers at reset values.
- rst asserted mid-access: can_ad_oe=0 on the next edge. No commit. No IR clear.
- Strobe/ALE pulses and AD setup/hold must be >= 3 clk. Shorter pulses are unsupported.
- rd_n low (pin) -> can_ad_oe=1 with valid data: 3 clk (2 sync + 1 reg).
- rd_n high -> can_ad_oe=0: 3 clk.
- wr_n rising (pin) -> wr_evt_o pulse and register updated: 3 clk.
- Register write -> can_int_n change: +1 clk (e.g. writing IER).
- irq_set_i -> can_int_n: 2 clk.
- Back-to-back accesses: a new ALE is accepted from IDLE or WAIT. No minimum gap beyond synchronizer latency.

## Test plan
- Reset: after rst, read addr 0 -> 0x01; read addr 5 -> 0x00; can_ad_oe=0; can_int_n=1.
- Write 0xA5 to addr 0x07 via the host initiator sequence, then read 0x07 -> 0xA5. wr_evt_o pulses once with wr_addr_o=0x07, wr_data_o=0xA5.
- Write 0x01 to IER (4); pulse irq_set_i=0x01 -> can_int_n=0 two clk later. Read IR -> 0x01; after rd_n rises IR=0 and can_int_n=1.
- irq_set_i=0x02 in the same cycle as the IR read-clear -> IR=0x02 afterward.
- Write to addr 0x03 and to 0x40 -> IR and reads unchanged; read 0x40 -> 0x00; wr_evt_o still pulses.
- Abort/reset: cs_n deasserted before wr_n rises -> no commit, no wr_evt_o. Separately, can_rst_n low for 4 clk after writing 0x55 to 0x07 -> read 0x07 = 0x00, mode = 0x01.
